exec_unit_param: RTL

- Parametrised successor to the 3-bit-ISA execute stage. Executes all eight opcodes internally: adv, bxl, bst, jnz, bxc, out, bdv, cdv.
- Holds registers A/B/C of DATA_W bits. Accepts one instruction per cycle over a valid/ready handshake.
- Buffers program output in an OUT_DEPTH FIFO with its own valid/ready handshake and stalls on FIFO-full.
- Sits between decode and the chip output mux; a jnz produces a registered redirect back to fetch.

---
 rtl/exec_unit_param_if.sv | 26 ++
 rtl/exec_unit_param.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/exec_unit_param_if.sv
// Instruction and output-FIFO handshake bundle for exec_unit_param.
// master = decode/consumer side, slave = execute unit.
interface exec_unit_param_if #(
    parameter int OUT_DEPTH = 4
);
    localparam int LVL_W = $clog2(OUT_DEPTH) + 1;

    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       opcode;
    logic [2:0]       operand;
    logic [2:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] out_level;

    modport master (
        output instr_valid, opcode, operand, out_ready,
        input  instr_ready, out_data, out_valid, out_level
    );

    modport slave (
        input  instr_valid, opcode, operand, out_ready,
        output instr_ready, out_data, out_valid, out_level
    );
endinterface

// File: rtl/exec_unit_param.sv
// Parametrised execute stage for the 3-bit ISA: A/B/C register file,
// output FIFO with backpressure and registered jnz redirect.
module exec_unit_param #(
    parameter int DATA_W    = 48,
    parameter int IP_W      = 5,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_regs,
    input  logic                A_lsb,
    input  logic                B_lsb,
    input  logic                C_lsb,
    exec_unit_param_if.slave    bus,
    output logic                redirect,
    output logic [IP_W-1:0]     redirect_ptr,
    output logic                reg_A_nz,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    exec_count
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_ADV = 3'd0,
        OP_BXL = 3'd1,
        OP_BST = 3'd2,
        OP_JNZ = 3'd3,
        OP_BXC = 3'd4,
        OP_OUT = 3'd5,
        OP_BDV = 3'd6,
        OP_CDV = 3'd7
    } op_e;

    logic [DATA_W-1:0] reg_a, reg_b, reg_c;
    logic [2:0]        fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;

    op_e               op;
    logic [DATA_W-1:0] combo;
    logic [DATA_W-1:0] shifted;
    logic              uses_combo;
    logic              fifo_full, fifo_empty;
    logic              ready_int, accept, push, pop, take_jump;

    assign op = op_e'(bus.opcode);

    always_comb begin
        combo = '0;
        case (bus.operand)
            3'd4:    combo = reg_a;
            3'd5:    combo = reg_b;
            3'd6:    combo = reg_c;
            3'd7:    combo = '0;
            default: combo = DATA_W'(bus.operand);
        endcase
    end

    // Shift amounts at or beyond the register width flush to zero.
    always_comb begin
        shifted = '0;
        if (combo < DATA_W'(DATA_W))
            shifted = reg_a >> combo;
    end

    assign uses_combo = op inside {OP_ADV, OP_BST, OP_OUT, OP_BDV, OP_CDV};

    assign fifo_full  = (level == LVL_W'(OUT_DEPTH));
    assign fifo_empty = (level == '0);

    // The out stall looks at the opcode only, so a same-cycle pop never frees a slot.
    assign ready_int = !init_regs && !redirect && !(op == OP_OUT && fifo_full);
    assign accept    = bus.instr_valid && ready_int;
    assign push      = accept && (op == OP_OUT);
    assign pop       = !fifo_empty && bus.out_ready && !init_regs;
    assign take_jump = accept && (op == OP_JNZ) && (reg_a != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
        end else if (init_regs) begin
            reg_a <= {reg_a[DATA_W-2:0], A_lsb};
            reg_b <= {reg_b[DATA_W-2:0], B_lsb};
            reg_c <= {reg_c[DATA_W-2:0], C_lsb};
        end else if (accept) begin
            case (op)
                OP_ADV:  reg_a <= shifted;
                OP_BXL:  reg_b <= reg_b ^ DATA_W'(bus.operand);
                OP_BST:  reg_b <= DATA_W'(combo[2:0]);
                OP_BXC:  reg_b <= reg_b ^ reg_c;
                OP_BDV:  reg_b <= shifted;
                OP_CDV:  reg_c <= shifted;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= combo[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (init_regs) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect     <= 1'b0;
            redirect_ptr <= '0;
            illegal_op   <= 1'b0;
            exec_count   <= '0;
        end else begin
            redirect <= take_jump;
            if (take_jump)
                redirect_ptr <= IP_W'(bus.operand);
            if (init_regs) begin
                illegal_op <= 1'b0;
                exec_count <= '0;
            end else if (accept) begin
                if (uses_combo && bus.operand == 3'd7)
                    illegal_op <= 1'b1;
                if (exec_count != '1)
                    exec_count <= exec_count + 1'b1;
            end
        end
    end

    assign bus.instr_ready = ready_int;
    assign bus.out_data    = fifo_mem[rd_ptr];
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_level   = level;
    assign reg_A_nz        = |reg_a;
endmodule
